// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader / memory-port arbiter.
package uart_boot_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } boot_state_e;

  localparam logic [1:0] OPSIZE_WORD = 2'b10;
  localparam int         LEN_BYTES   = 2;
  localparam int         WORD_BYTES  = 4;
endpackage

// File: rtl/boot_byte_assembler.sv
// Little-endian byte collector: each push shifts the new byte in at the top,
// so after four pushes the first byte sits in bits [7:0].
module boot_byte_assembler
  import uart_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [2:0]  cnt_o,
  output logic        word_ready_o
);
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o       = word_q;
  assign cnt_o        = cnt_q;
  assign word_ready_o = (cnt_q == 3'(WORD_BYTES));
endmodule

// File: rtl/uart_boot_arbiter.sv
// Shares the data-memory write port between the core and a UART program loader
// that receives a 16-bit word count followed by little-endian 32-bit words.
module uart_boot_arbiter
  import uart_boot_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE      = '0,
  parameter int                    MAX_WORDS      = 1024,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  boot_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [31:0]           cpu_wd_i,
  input  logic [1:0]            cpu_size_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  rx_pop_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wd_o,
  output logic [1:0]            mem_size_o,
  output logic                  cpu_stall_o,
  output logic                  boot_busy_o,
  output logic                  boot_done_o,
  output logic                  boot_err_o,
  output logic [15:0]           words_loaded_o
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  boot_state_e           state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wl_q, wl_d;
  logic [TW-1:0]         to_q, to_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [31:0]           hwd_q, hwd_d;
  logic [1:0]            hsize_q, hsize_d;

  logic        pop, asm_clr, asm_ready, to_hit;
  logic [31:0] asm_word;
  logic [2:0]  asm_cnt;
  logic [15:0] n_rx;
  logic [ADDR_WIDTH-1:0] waddr;

  boot_byte_assembler u_asm (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clr_i        (asm_clr),
    .push_i       (pop),
    .byte_i       (rx_byte_i),
    .word_o       (asm_word),
    .cnt_o        (asm_cnt),
    .word_ready_o (asm_ready)
  );

  // Word count is complete when the second byte arrives; the first is at [31:24].
  assign n_rx   = {rx_byte_i, asm_word[31:24]};
  assign waddr  = LOAD_BASE + ADDR_WIDTH'({wl_q, 2'b00});
  assign to_hit = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wl_d       = wl_q;
    to_d       = '0;
    haddr_d    = haddr_q;
    hwd_d      = hwd_q;
    hsize_d    = hsize_q;
    pop        = 1'b0;
    asm_clr    = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = haddr_q;
    mem_wd_o   = hwd_q;
    mem_size_o = hsize_q;
    case (state_q)
      S_IDLE: begin
        mem_we_o   = cpu_we_i & reset_i;
        mem_addr_o = cpu_addr_i;
        mem_wd_o   = cpu_wd_i;
        mem_size_o = cpu_size_i;
        haddr_d    = cpu_addr_i;
        hwd_d      = cpu_wd_i;
        hsize_d    = cpu_size_i;
        asm_clr    = 1'b1;
        if (boot_req_i) begin
          state_d = S_LEN;
          wl_d    = '0;
        end
      end
      S_LEN, S_COLLECT: begin
        pop = rx_valid_i;
        if (!rx_valid_i) begin
          to_d = to_q + TW'(1);
          if (to_hit) state_d = S_ERR;
        end else if (state_q == S_LEN) begin
          if (asm_cnt == 3'(LEN_BYTES - 1)) begin
            len_d   = n_rx;
            asm_clr = 1'b1;
            if (n_rx == 16'd0)                    state_d = S_DONE;
            else if (32'(n_rx) > 32'(MAX_WORDS))  state_d = S_ERR;
            else                                  state_d = S_COLLECT;
          end
        end else if (asm_cnt == 3'(WORD_BYTES - 1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we_o   = asm_ready;
        mem_addr_o = waddr;
        mem_wd_o   = asm_word;
        mem_size_o = OPSIZE_WORD;
        haddr_d    = waddr;
        hwd_d      = asm_word;
        hsize_d    = OPSIZE_WORD;
        asm_clr    = 1'b1;
        wl_d       = wl_q + 16'd1;
        state_d    = (wl_q + 16'd1 == len_q) ? S_DONE : S_COLLECT;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wl_q    <= '0;
      to_q    <= '0;
      haddr_q <= '0;
      hwd_q   <= '0;
      hsize_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      to_q    <= to_d;
      haddr_q <= haddr_d;
      hwd_q   <= hwd_d;
      hsize_q <= hsize_d;
    end
  end

  // Status outputs are forced low combinationally while reset is asserted.
  assign rx_pop_o       = pop & reset_i;
  assign boot_busy_o    = (state_q != S_IDLE) & reset_i;
  assign cpu_stall_o    = boot_busy_o;
  assign boot_done_o    = (state_q == S_DONE) & reset_i;
  assign boot_err_o     = (state_q == S_ERR) & reset_i;
  assign words_loaded_o = reset_i ? wl_q : 16'd0;
endmodule

// File: tb/tb_uart_boot_arbiter.sv
// Directed bench: table-driven pass-through vectors plus scripted load sessions
// against a byte-queue model of the RX FIFO.
module tb_uart_boot_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        boot_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wd = '0;
  logic [1:0]  cpu_size = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_pop, mem_we, cpu_stall, boot_busy, boot_done, boot_err;
  logic [31:0] mem_addr, mem_wd;
  logic [1:0]  mem_size;
  logic [15:0] words_loaded;

  uart_boot_arbiter #(
    .ADDR_WIDTH(32), .LOAD_BASE(32'h0000_0100), .MAX_WORDS(1024), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .boot_req_i(boot_req),
    .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd), .cpu_size_i(cpu_size),
    .rx_valid_i(rx_valid), .rx_byte_i(rx_byte), .rx_pop_o(rx_pop),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_size_o(mem_size),
    .cpu_stall_o(cpu_stall), .boot_busy_o(boot_busy), .boot_done_o(boot_done),
    .boot_err_o(boot_err), .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  q[$];
  logic [31:0] wa[$];
  logic [31:0] wdq[$];
  logic [1:0]  wsz[$];
  int n_done, n_err, n_pop, n_stall, done_cyc, err_cyc, pop_cyc;
  logic s_stall, s_busy, s_done, s_err, s_pop, s_memwe;
  logic [15:0] s_wl;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic        exp_we;
  } pt_vec_t;
  pt_vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    wa.delete(); wdq.delete(); wsz.delete();
    n_done = 0; n_err = 0; n_pop = 0; n_stall = 0;
    done_cyc = -1; err_cyc = -1; pop_cyc = -1;
  endtask

  task automatic cycle(input logic br);
    logic popped;
    @(negedge clk);
    boot_req = br;
    rx_valid = (q.size() > 0);
    rx_byte  = (q.size() > 0) ? q[0] : 8'h00;
    #1;
    if (mem_we && boot_busy) begin
      wa.push_back(mem_addr); wdq.push_back(mem_wd); wsz.push_back(mem_size);
    end
    if (boot_done) begin n_done++; done_cyc = cyc; end
    if (boot_err)  begin n_err++;  err_cyc  = cyc; end
    if (rx_pop)    begin n_pop++;  pop_cyc  = cyc; end
    if (cpu_stall) n_stall++;
    s_stall = cpu_stall; s_busy = boot_busy; s_done = boot_done; s_err = boot_err;
    s_pop = rx_pop; s_memwe = mem_we; s_wl = words_loaded;
    popped = rx_pop;
    @(posedge clk);
    if (popped) void'(q.pop_front());
    cyc++;
  endtask

  task automatic run_session(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle(1'b0);
      if (n_done + n_err > 0) break;
    end
    chk({nm, "_ended"}, 64'(n_done + n_err), 64'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2'b10, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_0000, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_A5A5, 2'b01, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_CAFE, 2'b10, 1'b0};

    // Reset held for two edges; outputs must read as reset values.
    clear_stats();
    reset = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    chk("rst_stall", 64'(s_stall), 64'd0);
    chk("rst_busy",  64'(s_busy),  64'd0);
    chk("rst_done",  64'(s_done),  64'd0);
    chk("rst_err",   64'(s_err),   64'd0);
    chk("rst_pop",   64'(s_pop),   64'd0);
    chk("rst_wl",    64'(s_wl),    64'd0);
    reset = 1'b1;

    // Idle pass-through table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      cpu_wd = vecs[i].wd; cpu_size = vecs[i].size;
      #1;
      chk($sformatf("pt%0d_we", i),    64'(mem_we),    64'(vecs[i].exp_we));
      chk($sformatf("pt%0d_addr", i),  64'(mem_addr),  64'(vecs[i].addr));
      chk($sformatf("pt%0d_wd", i),    64'(mem_wd),    64'(vecs[i].wd));
      chk($sformatf("pt%0d_size", i),  64'(mem_size),  64'(vecs[i].size));
      chk($sformatf("pt%0d_stall", i), 64'(cpu_stall), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1; cpu_we = 1'b0;

    // Normal two-word load; core store attempts during the session are ignored
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_stats();
    cycle(1'b1);
    chk("load_stall_on_req", 64'(s_stall), 64'd0);
    cpu_we = 1'b1; cpu_addr = 32'h0000_0999; cpu_wd = 32'h1357_9BDF;
    run_session("load", 80);
    cpu_we = 1'b0;
    chk("load_nwrites", 64'(wa.size()), 64'd2);
    chk("load_a0", 64'(wa[0]),  64'h100);
    chk("load_d0", 64'(wdq[0]), 64'h4433_2211);
    chk("load_s0", 64'(wsz[0]), 64'd2);
    chk("load_a1", 64'(wa[1]),  64'h104);
    chk("load_d1", 64'(wdq[1]), 64'hDDCC_BBAA);
    chk("load_done", 64'(n_done), 64'd1);
    chk("load_err",  64'(n_err),  64'd0);
    chk("load_pops", 64'(n_pop),  64'd10);
    chk("load_stall_cycles", 64'(n_stall), 64'd13);
    cycle(1'b0);
    chk("load_stall_after", 64'(s_stall), 64'd0);
    chk("load_busy_after",  64'(s_busy),  64'd0);
    chk("load_wl",          64'(s_wl),    64'd2);

    // Zero-length session
    q = '{8'h00, 8'h00};
    clear_stats();
    cycle(1'b1);
    run_session("zero", 20);
    chk("zero_nwrites", 64'(wa.size()), 64'd0);
    chk("zero_done", 64'(n_done), 64'd1);
    chk("zero_done_lat", 64'(done_cyc - pop_cyc), 64'd1);
    cycle(1'b0);
    chk("zero_wl", 64'(s_wl), 64'd0);

    // Oversized lengths: 0xFFFF and MAX_WORDS+1
    q = '{8'hFF, 8'hFF};
    clear_stats();
    cycle(1'b1);
    run_session("bigffff", 20);
    chk("bigffff_err", 64'(n_err), 64'd1);
    chk("bigffff_done", 64'(n_done), 64'd0);
    chk("bigffff_nwrites", 64'(wa.size()), 64'd0);
    chk("bigffff_lat", 64'(err_cyc - pop_cyc), 64'd1);
    cycle(1'b0);
    chk("bigffff_idle", 64'(s_busy), 64'd0);

    q = '{8'h01, 8'h04};
    clear_stats();
    cycle(1'b1);
    run_session("big1025", 20);
    chk("big1025_err", 64'(n_err), 64'd1);
    chk("big1025_nwrites", 64'(wa.size()), 64'd0);

    // Timeout with FIFO starved after 3 bytes; boot_req pulses are ignored
    q = '{8'h02, 8'h00, 8'h11};
    clear_stats();
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    run_session("tmo", 60);
    chk("tmo_err", 64'(n_err), 64'd1);
    chk("tmo_done", 64'(n_done), 64'd0);
    chk("tmo_pops", 64'(n_pop), 64'd3);
    chk("tmo_lat", 64'(err_cyc - pop_cyc), 64'd17);
    chk("tmo_wl", 64'(s_wl), 64'd0);
    cycle(1'b0);
    chk("tmo_idle", 64'(s_busy), 64'd0);

    // Reset mid-COLLECT, then a clean session
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_stats();
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    chk("mid_busy_before", 64'(s_busy), 64'd1);
    reset = 1'b0; cpu_we = 1'b1;
    cycle(1'b0);
    chk("midrst_memwe", 64'(s_memwe), 64'd0);
    chk("midrst_stall", 64'(s_stall), 64'd0);
    chk("midrst_pop",   64'(s_pop),   64'd0);
    reset = 1'b1; cpu_we = 1'b0;
    clear_stats();
    cycle(1'b0);
    chk("postrst_busy", 64'(s_busy), 64'd0);
    chk("postrst_err",  64'(n_err),  64'd0);
    chk("postrst_pop",  64'(n_pop),  64'd0);
    chk("postrst_wl",   64'(s_wl),   64'd0);
    q.delete();
    q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_stats();
    cycle(1'b1);
    run_session("clean", 40);
    chk("clean_nwrites", 64'(wa.size()), 64'd1);
    chk("clean_a0", 64'(wa[0]),  64'h100);
    chk("clean_d0", 64'(wdq[0]), 64'hEFBE_ADDE);
    chk("clean_done", 64'(n_done), 64'd1);
    cycle(1'b0);
    chk("clean_wl", 64'(s_wl), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
